dpram_be_clr: RTL
=================

// Module: dpram_be_clr
// PURPOSE
//  Single-clock true dual-port RAM: parametrised width/depth, per-byte write enables,
//  selectable read-during-write mode, deterministic A/B collision arbitration.
//  Built-in clear engine fills every word with CLEAR_VALUE after reset or on request.
//  Drop-in for video/work RAMs that must start from a known state after reset.
// PARAMETERS
//  ADDR_W       11     address width; depth = 2**ADDR_W words
//  DATA_W       8      word width; must be a multiple of BYTE_W
//  BYTE_W       8      bits per byte lane; NBE = DATA_W/BYTE_W lanes
//  RDW_MODE     0      same-port read-during-write: 0 = old data, 1 = new (merged) data
//  CLEAR_VALUE  0      DATA_W-bit value written to every word by the clear engine
// PORTS
//  clock      in   1        single clock, rising edge
//  reset_n    in   1        asynchronous active-low reset
//  clear_req  in   1        pulse: start a full clear (ignored while busy)
//  busy       out  1        1 while the clear engine owns the array
//  enable_a   in   1        port A access enable
//  wren_a     in   1        port A write
//  be_a       in   NBE      port A byte-lane write enables
//  address_a  in   ADDR_W   port A address
//  data_a     in   DATA_W   port A write data
//  q_a        out  DATA_W   port A read data
//  enable_b, wren_b, be_b, address_b, data_b, q_b: same as port A, for port B
// BEHAVIOUR
//  Reset (async, reset_n=0): q_a=q_b=0, busy=1, state=CLEAR, clr_addr=0. Array not reset.
//  FSM: CLEAR -> READY when clr_addr==2**ADDR_W-1 (that last word is written that cycle);
//       READY -> CLEAR on clear_req=1 (clr_addr<=0). clear_req in CLEAR: ignored.
//  CLEAR: one word per cycle, mem[clr_addr]<=CLEAR_VALUE, clr_addr++. Full clear = 2**ADDR_W
//       cycles; busy deasserts on the edge that writes the last word. Port writes dropped;
//       q_a/q_b hold their value. reset_n low mid-clear restarts at address 0.
//  READY, per port X (registered read, 1-cycle latency):
//   - enable_X=0: no access, q_X holds.
//   - enable_X=1, wren_X=0: q_X <= mem[address_X] on next edge.
//   - enable_X=1, wren_X=1: lane i written iff be_X[i]; q_X <= old word (RDW_MODE=0)
//     or word with written lanes merged (RDW_MODE=1). wren_X=1 with be_X=0: plain read.
//  Collision (both write, same address, same cycle): per lane, A wins if be_a[i]=1,
//     else B's lane written if be_b[i]=1.
//  Cross-port read of an address the other port writes this cycle: returns old data.
//  Pure combinational logic beyond registered reads is limited to lane merge / arbitration.
// CONFIGURATION
//  DPRAM_OUTREG_EN defined: extra output register on q_a/q_b; read latency 2 cycles;
//     the pipeline stage advances only when that port's enable was high on the
//     previous cycle; stage resets to 0.
//  DPRAM_OUTREG_EN undefined: read latency 1 cycle as above.
// TESTING
//  1 reset_n 0->1, ADDR_W=4, CLEAR_VALUE=8'hA5 -> busy high exactly 16 cycles; then reads
//    of every address return 8'hA5.
//  2 DATA_W=16, A writes 16'h1234 @3, then B reads @3 -> q_b=16'h1234 one cycle later;
//    A write be_a=2'b01 data 16'hFFFF @3 -> readback 16'h12FF.
//  3 RDW_MODE=0: A writes 16'hBEEF over 16'h1234 @5 -> q_a=16'h1234 next cycle;
//    RDW_MODE=1: same stimulus -> q_a=16'hBEEF.
//  4 Collision @7: A writes 16'hAAAA be_a=2'b10, B writes 16'hBBBB be_b=2'b11 ->
//    mem[7]=16'hAABB.
//  5 clear_req in READY mid-traffic -> busy next cycle, port writes dropped, q holds;
//    reset_n pulsed at clr_addr=8 -> clear restarts at 0, busy stays high 16 more cycles.
//  6 DPRAM_OUTREG_EN defined: read @3 -> data on q_a 2 cycles later; enable low holds q.

Source files
------------

// File: rtl/dpram_be_clr_if.sv
// ============================================================================
//  Module      : dpram_be_clr_if
//  Description : Bus bundle for dpram_be_clr: clear control plus two
//                independent RAM access ports (A and B) with byte enables.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dpram_be_clr_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8,
   parameter int BYTE_W = 8
);
   localparam int c_NBE = DATA_W / BYTE_W;

   logic              clear_req;
   logic              busy;

   logic              enable_a;
   logic              wren_a;
   logic [c_NBE-1:0]  be_a;
   logic [ADDR_W-1:0] address_a;
   logic [DATA_W-1:0] data_a;
   logic [DATA_W-1:0] q_a;

   logic              enable_b;
   logic              wren_b;
   logic [c_NBE-1:0]  be_b;
   logic [ADDR_W-1:0] address_b;
   logic [DATA_W-1:0] data_b;
   logic [DATA_W-1:0] q_b;

   // Requesting side: drives accesses, observes read data and busy
   modport master (
      output clear_req,
      output enable_a, wren_a, be_a, address_a, data_a,
      output enable_b, wren_b, be_b, address_b, data_b,
      input  busy, q_a, q_b
   );

   // RAM side
   modport slave (
      input  clear_req,
      input  enable_a, wren_a, be_a, address_a, data_a,
      input  enable_b, wren_b, be_b, address_b, data_b,
      output busy, q_a, q_b
   );
endinterface

`default_nettype wire

// File: rtl/dpram_be_clr.sv
// ============================================================================
//  Module      : dpram_be_clr
//  Description : Single-clock true dual-port RAM with per-byte write enables,
//                selectable same-port read-during-write behaviour, A-over-B
//                lane arbitration on colliding writes and a clear engine that
//                fills the whole array with CLEAR_VALUE after reset or on
//                request.
//                Optional macro DPRAM_OUTREG_EN adds a second output register
//                on q_a/q_b (read latency 2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dpram_be_clr #(
   parameter int              ADDR_W      = 11,
   parameter int              DATA_W      = 8,
   parameter int              BYTE_W      = 8,
   parameter int              RDW_MODE    = 0,
   parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
   input  logic           clock,
   input  logic           reset_n,
   dpram_be_clr_if.slave  bus
);
   localparam int c_NBE   = DATA_W / BYTE_W;
   localparam int c_DEPTH = 2 ** ADDR_W;

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_READY = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_clr_addr;
   logic [ADDR_W-1:0] w_clr_addr_nxt;
   logic              w_busy;

   logic [DATA_W-1:0] r_mem [0:c_DEPTH-1];

   logic [c_NBE-1:0]  w_wr_a;
   logic [c_NBE-1:0]  w_wr_b;
   logic [DATA_W-1:0] w_rd_a;
   logic [DATA_W-1:0] w_rd_b;
   logic [DATA_W-1:0] w_mrg_a;
   logic [DATA_W-1:0] w_mrg_b;
   logic [DATA_W-1:0] r_q_a;
   logic [DATA_W-1:0] r_q_b;

   assign w_busy   = (r_state == S_CLEAR);
   assign bus.busy = w_busy;

   // State and clear-address registers; reset restarts the clear from word 0
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_CLEAR;
         r_clr_addr <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_clr_addr <= w_clr_addr_nxt;
      end
   end

   // Next state: sweep the array once, then serve ports until a clear request
   always_comb begin
      w_state_nxt    = r_state;
      w_clr_addr_nxt = r_clr_addr;
      case (r_state)
         S_CLEAR: begin
            w_clr_addr_nxt = r_clr_addr + 1'b1;
            if (&r_clr_addr) begin
               w_state_nxt = S_READY;
            end
         end
         S_READY: begin
            if (bus.clear_req) begin
               w_state_nxt    = S_CLEAR;
               w_clr_addr_nxt = '0;
            end
         end
         default: begin
            w_state_nxt    = S_CLEAR;
            w_clr_addr_nxt = '0;
         end
      endcase
   end

   // Lane write strobes; a B lane yields to A when both hit the same word
   always_comb begin
      w_wr_a = '0;
      w_wr_b = '0;
      for (int i = 0; i < c_NBE; i++) begin
         w_wr_a[i] = !w_busy && bus.enable_a && bus.wren_a && bus.be_a[i];
         w_wr_b[i] = !w_busy && bus.enable_b && bus.wren_b && bus.be_b[i] &&
                     !(w_wr_a[i] && (bus.address_a == bus.address_b));
      end
   end

   assign w_rd_a = r_mem[bus.address_a];
   assign w_rd_b = r_mem[bus.address_b];

   // Old word with this port's own written lanes substituted (new-data view)
   always_comb begin
      w_mrg_a = w_rd_a;
      w_mrg_b = w_rd_b;
      for (int i = 0; i < c_NBE; i++) begin
         if (w_wr_a[i]) begin
            w_mrg_a[i*BYTE_W +: BYTE_W] = bus.data_a[i*BYTE_W +: BYTE_W];
         end
         if (w_wr_b[i]) begin
            w_mrg_b[i*BYTE_W +: BYTE_W] = bus.data_b[i*BYTE_W +: BYTE_W];
         end
      end
   end

   // Array update: clear engine owns it while busy, otherwise per-lane writes
   always_ff @(posedge clock) begin
      if (w_busy) begin
         r_mem[r_clr_addr] <= CLEAR_VALUE;
      end else begin
         for (int i = 0; i < c_NBE; i++) begin
            if (w_wr_a[i]) begin
               r_mem[bus.address_a][i*BYTE_W +: BYTE_W] <= bus.data_a[i*BYTE_W +: BYTE_W];
            end
            if (w_wr_b[i]) begin
               r_mem[bus.address_b][i*BYTE_W +: BYTE_W] <= bus.data_b[i*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   // Registered reads; outputs hold while disabled or while clearing
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_q_a <= '0;
         r_q_b <= '0;
      end else begin
         if (!w_busy && bus.enable_a) begin
            r_q_a <= (RDW_MODE != 0) ? w_mrg_a : w_rd_a;
         end
         if (!w_busy && bus.enable_b) begin
            r_q_b <= (RDW_MODE != 0) ? w_mrg_b : w_rd_b;
         end
      end
   end

`ifdef DPRAM_OUTREG_EN
   logic              r_en_a_d;
   logic              r_en_b_d;
   logic [DATA_W-1:0] r_q2_a;
   logic [DATA_W-1:0] r_q2_b;

   // Output stage advances only behind a cycle in which the port was enabled
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_en_a_d <= 1'b0;
         r_en_b_d <= 1'b0;
         r_q2_a   <= '0;
         r_q2_b   <= '0;
      end else begin
         r_en_a_d <= bus.enable_a;
         r_en_b_d <= bus.enable_b;
         if (r_en_a_d) begin
            r_q2_a <= r_q_a;
         end
         if (r_en_b_d) begin
            r_q2_b <= r_q_b;
         end
      end
   end

   assign bus.q_a = r_q2_a;
   assign bus.q_b = r_q2_b;
`else
   assign bus.q_a = r_q_a;
   assign bus.q_b = r_q_b;
`endif

endmodule

`default_nettype wire
